// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment digit decoder.
//   - legal gfedcba patterns for the digits 0..9 (active-high segments)
//   - decoder FSM state enumeration
//   - digit width
package seg_pkg;

    localparam int unsigned DigitW = 4;
    localparam int unsigned SegW   = 7;

    localparam logic [SegW-1:0] Pat0 = 7'h3F;
    localparam logic [SegW-1:0] Pat1 = 7'h06;
    localparam logic [SegW-1:0] Pat2 = 7'h5B;
    localparam logic [SegW-1:0] Pat3 = 7'h4F;
    localparam logic [SegW-1:0] Pat4 = 7'h66;
    localparam logic [SegW-1:0] Pat5 = 7'h6D;
    localparam logic [SegW-1:0] Pat6 = 7'h7D;
    localparam logic [SegW-1:0] Pat7 = 7'h07;
    localparam logic [SegW-1:0] Pat8 = 7'h7F;
    localparam logic [SegW-1:0] Pat9 = 7'h6F;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDone,
        StWaitChg
    } state_e;

endpackage

// File: rtl/seg_lut.sv
// seg_lut: combinational seven-segment pattern to digit lookup.
//   pat_i   - gfedcba pattern, active-high segments
//   digit_o - decoded digit 0..9 (0 when the pattern is illegal)
//   legal_o - pattern is one of the ten digit patterns
module seg_lut
    import seg_pkg::*;
(
    input  logic [SegW-1:0]   pat_i,
    output logic [DigitW-1:0] digit_o,
    output logic              legal_o
);

    always_comb begin
        digit_o = '0;
        legal_o = 1'b1;
        case (pat_i)
            Pat0:    digit_o = 4'd0;
            Pat1:    digit_o = 4'd1;
            Pat2:    digit_o = 4'd2;
            Pat3:    digit_o = 4'd3;
            Pat4:    digit_o = 4'd4;
            Pat5:    digit_o = 4'd5;
            Pat6:    digit_o = 4'd6;
            Pat7:    digit_o = 4'd7;
            Pat8:    digit_o = 4'd8;
            Pat9:    digit_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_decoder.sv
// seg_decoder: debounced seven-segment digit decoder.
// A pattern must be sampled STABLE_CYCLES times in a row before it is decoded;
// a held pattern decodes once only. Illegal stable patterns raise dec_error.
//   clk, reset            - clock, synchronous active-high reset
//   seg_in, seg_valid     - gfedcba sample and its qualifier
//   seg_ready             - low only in the one-cycle decode state
//   bcd, sum, carry       - last decoded digit, its bits [1:0] and bit [2]
//   out_of_range          - last decoded digit > 6
//   dec_valid, dec_error  - one-cycle decode result pulses
//   err_count             - saturating count of dec_error pulses
module seg_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SegW-1:0]   seg_in,
    input  logic              seg_valid,
    output logic              seg_ready,
    output logic [DigitW-1:0] bcd,
    output logic [1:0]        sum,
    output logic              carry,
    output logic              dec_valid,
    output logic              out_of_range,
    output logic              dec_error,
    output logic [7:0]        err_count
);

    localparam logic [3:0] StableCnt = 4'(STABLE_CYCLES);

    state_e              state_q, state_d;
    logic [SegW-1:0]     shadow_q, shadow_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DigitW-1:0]   bcd_q, bcd_d;
    logic [7:0]          err_q, err_d;
    logic [SegW-1:0]     seg_adj;
    logic [DigitW-1:0]   lut_digit;
    logic                lut_legal;
    logic                load, inc;

    // Shadow holds the polarity-corrected pattern, so compare and lookup agree.
    assign seg_adj = SEG_ACTIVE_LOW ? ~seg_in : seg_in;

    seg_lut u_lut (
        .pat_i   (shadow_q),
        .digit_o (lut_digit),
        .legal_o (lut_legal)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        err_d    = err_q;
        load     = 1'b0;
        inc      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (seg_valid) load = 1'b1;
            end
            StSettle: begin
                if (seg_valid) begin
                    if (seg_adj == shadow_q) inc = 1'b1;
                    else                     load = 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StWaitChg;
                if (lut_legal)            bcd_d = lut_digit;
                else if (err_q != 8'hFF)  err_d = err_q + 8'd1;
            end
            StWaitChg: begin
                if (seg_valid) begin
                    if (seg_adj != shadow_q) load = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shadow_d = seg_adj;
            cnt_d    = 4'd1;
        end
        if (inc) begin
            cnt_d = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
        end
        // The sample that completes the run moves straight to the decode state.
        if (load || inc) begin
            state_d = (cnt_d >= StableCnt) ? StDone : StSettle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            err_q    <= err_d;
        end
    end

    assign seg_ready = (state_q != StDone);
    assign dec_valid = (state_q == StDone) && lut_legal;
    assign dec_error = (state_q == StDone) && !lut_legal;

    // Next-state values let the decode cycle already show its new result.
    assign bcd          = bcd_d;
    assign err_count    = err_d;
    assign sum          = bcd[1:0];
    assign carry        = bcd[2];
    assign out_of_range = (bcd > 4'd6);

endmodule

// File: tb/tb_seg_decoder.sv
module tb_seg_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [6:0] seg_in, seg_in_l;
    logic       seg_valid, seg_valid_l, seg_valid_s;

    logic       rdy_a, cy_a, dv_a, oor_a, de_a;
    logic [3:0] bcd_a;
    logic [1:0] sum_a;
    logic [7:0] errc_a;
    logic       rdy_l, cy_l, dv_l, oor_l, de_l;
    logic [3:0] bcd_l;
    logic [1:0] sum_l;
    logic [7:0] errc_l;
    logic       rdy_s, cy_s, dv_s, oor_s, de_s;
    logic [3:0] bcd_s;
    logic [1:0] sum_s;
    logic [7:0] errc_s;

    seg_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid),
        .seg_ready(rdy_a), .bcd(bcd_a), .sum(sum_a), .carry(cy_a), .dec_valid(dv_a),
        .out_of_range(oor_a), .dec_error(de_a), .err_count(errc_a)
    );

    seg_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) u_dut_l (
        .clk(clk), .reset(reset), .seg_in(seg_in_l), .seg_valid(seg_valid_l),
        .seg_ready(rdy_l), .bcd(bcd_l), .sum(sum_l), .carry(cy_l), .dec_valid(dv_l),
        .out_of_range(oor_l), .dec_error(de_l), .err_count(errc_l)
    );

    seg_decoder #(.STABLE_CYCLES(1), .SEG_ACTIVE_LOW(1'b0)) u_dut_s (
        .clk(clk), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid_s),
        .seg_ready(rdy_s), .bcd(bcd_s), .sum(sum_s), .carry(cy_s), .dec_valid(dv_s),
        .out_of_range(oor_s), .dec_error(de_s), .err_count(errc_s)
    );

    typedef struct packed {
        logic       dv;
        logic       de;
        logic [3:0] bcd;
        logic [1:0] sum;
        logic       carry;
        logic       oor;
        logic [7:0] errc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    logic [6:0]  pat_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [3:0]  bcd_m  = 4'd0;
    int unsigned errc_m = 0;

    // Record every result pulse of the main instance.
    always @(negedge clk) begin
        if (reset === 1'b0 && (dv_a === 1'b1 || de_a === 1'b1)) begin
            ev_t o;
            o.dv = dv_a; o.de = de_a; o.bcd = bcd_a; o.sum = sum_a;
            o.carry = cy_a; o.oor = oor_a; o.errc = errc_a;
            obs_q.push_back(o);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push_digit(input int d);
        ev_t e;
        bcd_m = 4'(d);
        e.dv = 1'b1; e.de = 1'b0; e.bcd = bcd_m; e.sum = bcd_m[1:0];
        e.carry = bcd_m[2]; e.oor = (d > 6); e.errc = 8'(errc_m);
        exp_q.push_back(e);
    endtask

    task automatic push_error();
        ev_t e;
        if (errc_m < 255) errc_m++;
        e.dv = 1'b0; e.de = 1'b1; e.bcd = bcd_m; e.sum = bcd_m[1:0];
        e.carry = bcd_m[2]; e.oor = (bcd_m > 4'd6); e.errc = 8'(errc_m);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            seg_valid = v;
            seg_in    = p;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 7'h00, 2);
        reset = 1'b0;
        drive(1'b0, 7'h00, 1);
        n_cmp++;
        if ({rdy_a, rdy_l, rdy_s} !== 3'b111) begin
            n_fail++; $display("FAIL reset_ready: got %b, need 111", {rdy_a, rdy_l, rdy_s});
        end
        n_cmp++;
        if ({bcd_a, sum_a, cy_a, oor_a} !== 8'h00) begin
            n_fail++; $display("FAIL reset_digit: got %h, need 00", {bcd_a, sum_a, cy_a, oor_a});
        end
        n_cmp++;
        if ({dv_a, de_a} !== 2'b00) begin
            n_fail++; $display("FAIL reset_pulses: got %b, need 00", {dv_a, de_a});
        end
        n_cmp++;
        if (errc_a !== 8'd0) begin
            n_fail++; $display("FAIL reset_errc: got %0d, need 0", errc_a);
        end
    endtask

    task automatic test_latency();
        push_digit(2);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 7'h5B, 1);
            n_cmp++;
            if (dv_a !== (i == 3)) begin
                n_fail++; $display("FAIL latency_c%0d: dec_valid %b, need %b", i, dv_a, i == 3);
            end
        end
        drive(1'b0, 7'h00, 2);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL latency_count: got %0d, need %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL latency_ev: got %h, need %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_hold();
        push_digit(6);
        drive(1'b1, 7'h7D, 20);
        push_digit(4);
        drive(1'b1, 7'h66, 4);
        n_cmp++;
        if (dv_a !== 1'b1) begin
            n_fail++; $display("FAIL hold_second: dec_valid %b, need 1", dv_a);
        end
        drive(1'b0, 7'h00, 2);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL hold_count: got %0d, need %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL hold_ev: got %h, need %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        push_digit(1);
        drive(1'b1, 7'h4F, 2);
        drive(1'b1, 7'h06, 4);
        drive(1'b0, 7'h00, 2);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d, need %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL glitch_ev: got %h, need %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_digits();
        for (int d = 0; d < 10; d++) begin
            push_digit(d);
            drive(1'b1, pat_tbl[d], 4);
            drive(1'b0, 7'h00, 1);
        end
        drive(1'b0, 7'h00, 1);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL digits_count: got %0d, need %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL digits_ev: got %h, need %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_active_low();
        seg_valid_l = 1'b1;
        seg_in_l    = 7'h00;
        drive(1'b0, 7'h00, 4);
        n_cmp++;
        if ({dv_l, de_l, bcd_l, sum_l, cy_l, oor_l} !== {2'b10, 4'd8, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL low_eight: got %b, need 10100000001", {dv_l, de_l, bcd_l, sum_l, cy_l, oor_l});
        end
        seg_valid_l = 1'b0;
        drive(1'b0, 7'h00, 2);
        seg_valid_l = 1'b1;
        seg_in_l    = ~7'h06;
        drive(1'b0, 7'h00, 4);
        n_cmp++;
        if ({dv_l, bcd_l, oor_l} !== {1'b1, 4'd1, 1'b0}) begin
            n_fail++; $display("FAIL low_one: got %b, need 100010", {dv_l, bcd_l, oor_l});
        end
        seg_valid_l = 1'b0;
        drive(1'b0, 7'h00, 2);
    endtask

    task automatic test_stable1();
        int extra;
        seg_valid_s = 1'b1;
        drive(1'b0, 7'h06, 1);
        n_cmp++;
        if ({dv_s, bcd_s} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL s1_first: got %b, need 10001", {dv_s, bcd_s});
        end
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 7'h06, 1);
            if (dv_s === 1'b1 || de_s === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin n_fail++; $display("FAIL s1_held: got %0d pulses, need 0", extra); end
        drive(1'b0, 7'h5B, 1);
        n_cmp++;
        if ({dv_s, bcd_s, sum_s} !== {1'b1, 4'd2, 2'd2}) begin
            n_fail++; $display("FAIL s1_change: got %b, need 1001010", {dv_s, bcd_s, sum_s});
        end
        seg_valid_s = 1'b0;
        drive(1'b0, 7'h00, 2);
    endtask

    task automatic test_errors();
        push_error();
        drive(1'b1, 7'h00, 4);
        drive(1'b0, 7'h00, 2);
        n_cmp++;
        if (bcd_a !== bcd_m) begin
            n_fail++; $display("FAIL err_bcd_kept: got %0d, need %0d", bcd_a, bcd_m);
        end
        for (int k = 0; k < 300; k++) begin
            push_error();
            drive(1'b1, (k % 2 == 0) ? 7'h00 : 7'h7E, 4);
            drive(1'b0, 7'h00, 2);
        end
        n_cmp++;
        if (errc_a !== 8'd255) begin
            n_fail++; $display("FAIL err_saturate: got %0d, need 255", errc_a);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL err_count: got %0d, need %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL err_ev: got %h, need %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 7'h3F, 2);
        reset = 1'b1;
        drive(1'b1, 7'h3F, 1);
        reset  = 1'b0;
        errc_m = 0;
        bcd_m  = 4'd0;
        drive(1'b0, 7'h00, 6);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL rstmid_pulses: got %0d, need 0", obs_q.size());
        end
        n_cmp++;
        if ({bcd_a, sum_a, cy_a, oor_a, dv_a, de_a, errc_a} !== 18'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h, need 0", {bcd_a, sum_a, cy_a, oor_a, dv_a, de_a, errc_a});
        end
        n_cmp++;
        if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b, need 1", rdy_a); end
        obs_q.delete();
    endtask

    initial begin
        reset       = 1'b1;
        seg_in      = 7'h00;
        seg_valid   = 1'b0;
        seg_in_l    = 7'h00;
        seg_valid_l = 1'b0;
        seg_valid_s = 1'b0;
        test_reset();
        test_latency();
        test_hold();
        test_glitch();
        test_digits();
        test_active_low();
        test_stable1();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
